// File: rtl/stat_updt_sched.sv
// Update/read scheduler in front of the 1024-entry statistics RAM block.
// Define STAT_SCHED_OVF_FLAG_EN to enable the sticky per-requester drop flags (vUpdtOvf).
module stat_updt_sched #(
    parameter int REQ_CNT           = 4,
    parameter int INC_LEN_BIT_WIDTH = 1,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                                 Clock,
    input  logic                                 nReset,
    input  logic [REQ_CNT-1:0]                   vUpdtReq,
    input  logic [REQ_CNT*10-1:0]                vUpdtIndex,
    input  logic [REQ_CNT*INC_LEN_BIT_WIDTH-1:0] vUpdtNum,
    output logic [REQ_CNT-1:0]                   vUpdtFull,
    output logic [REQ_CNT-1:0]                   vUpdtOvf,
    input  logic                                 HostRdReq,
    input  logic [9:0]                           HostRdAddr,
    output logic                                 HostRdAck,
    output logic                                 HostRdVal,
    output logic [63:0]                          HostRdData,
    output logic                                 qStatUpdtReq,
    output logic [9:0]                           qvStatUpdtReqIndex,
    output logic [INC_LEN_BIT_WIDTH-1:0]         qvStatUpdtNum,
    output logic                                 qStatREn,
    output logic [9:0]                           qvStatRAddr,
    input  logic [63:0]                          qvStatRData
);

    localparam int ENTRY_W = 10 + INC_LEN_BIT_WIDTH;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int PW      = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;

    logic [REQ_CNT-1:0]              pushEn;
    logic [REQ_CNT-1:0]              avail;
    logic [REQ_CNT-1:0]              popEn;
    logic [REQ_CNT-1:0][ENTRY_W-1:0] headData;
    logic                            anyAvail;
    logic                            grantEn;
    logic [PW-1:0]                   rrPtr;
    logic [PW-1:0]                   winIdx;

    generate
        for (genvar gi = 0; gi < REQ_CNT; gi++) begin : gFifo
            logic [ENTRY_W-1:0] fifoMem [FIFO_DEPTH];
            logic [AW-1:0]      wrPtr;
            logic [AW-1:0]      rdPtr;
            logic [CW-1:0]      count;
            logic [CW-1:0]      countNext;
            logic               fullReg;
            logic               isEmpty;
            logic               wrEn;
            logic               rdEn;
            logic [ENTRY_W-1:0] inEntry;

            assign inEntry      = {vUpdtIndex[10*gi +: 10],
                                   vUpdtNum[INC_LEN_BIT_WIDTH*gi +: INC_LEN_BIT_WIDTH]};
            assign isEmpty      = (count == '0);
            assign pushEn[gi]   = vUpdtReq[gi] & ~fullReg;
            assign avail[gi]    = ~isEmpty | pushEn[gi];
            assign headData[gi] = isEmpty ? inEntry : fifoMem[rdPtr];
            // Popping an empty FIFO means the same-cycle push goes straight through
            assign wrEn         = pushEn[gi] & ~(popEn[gi] & isEmpty);
            assign rdEn         = popEn[gi] & ~isEmpty;
            assign vUpdtFull[gi] = fullReg;

            always_comb begin
                countNext = count;
                if (wrEn && !rdEn) begin
                    countNext = count + CW'(1);
                end else if (!wrEn && rdEn) begin
                    countNext = count - CW'(1);
                end
            end

            always_ff @(posedge Clock) begin
                if (!nReset) begin
                    wrPtr   <= '0;
                    rdPtr   <= '0;
                    count   <= '0;
                    fullReg <= 1'b0;
                end else begin
                    if (wrEn) wrPtr <= wrPtr + AW'(1);
                    if (rdEn) rdPtr <= rdPtr + AW'(1);
                    count   <= countNext;
                    fullReg <= (countNext == CW'(FIFO_DEPTH));
                end
            end

            always_ff @(posedge Clock) begin
                if (wrEn) fifoMem[wrPtr] <= inEntry;
            end

`ifdef STAT_SCHED_OVF_FLAG_EN
            logic ovfReg;
            always_ff @(posedge Clock) begin
                if (!nReset) begin
                    ovfReg <= 1'b0;
                end else if (vUpdtReq[gi] && fullReg) begin
                    ovfReg <= 1'b1;
                end
            end
            assign vUpdtOvf[gi] = ovfReg;
`else
            assign vUpdtOvf[gi] = 1'b0;
`endif
        end
    endgenerate

    // Round-robin search starting at rrPtr
    always_comb begin : pArb
        int cand;
        cand     = 0;
        anyAvail = 1'b0;
        winIdx   = '0;
        for (int k = 0; k < REQ_CNT; k++) begin
            cand = int'(rrPtr) + k;
            if (cand >= REQ_CNT) cand = cand - REQ_CNT;
            if (!anyAvail && avail[cand]) begin
                anyAvail = 1'b1;
                winIdx   = PW'(cand);
            end
        end
    end

    assign grantEn = anyAvail & ~qStatUpdtReq;
    assign popEn   = grantEn ? (REQ_CNT'(1) << winIdx) : '0;

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            qStatUpdtReq       <= 1'b0;
            qvStatUpdtReqIndex <= '0;
            qvStatUpdtNum      <= '0;
            rrPtr              <= '0;
        end else begin
            qStatUpdtReq <= grantEn;
            if (grantEn) begin
                {qvStatUpdtReqIndex, qvStatUpdtNum} <= headData[winIdx];
                rrPtr <= (winIdx == PW'(REQ_CNT - 1)) ? '0 : winIdx + PW'(1);
            end
        end
    end

    typedef enum logic [1:0] {RD_IDLE, RD_ISSUE, RD_WAIT1, RD_WAIT2} rdState_t;
    rdState_t    rdState;
    rdState_t    rdStateNext;
    logic [9:0]  rdAddrReg;
    logic [63:0] rdDataReg;

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            rdState <= RD_IDLE;
        end else begin
            rdState <= rdStateNext;
        end
    end

    always_comb begin
        rdStateNext = rdState;
        qStatREn    = 1'b0;
        HostRdAck   = 1'b0;
        HostRdVal   = 1'b0;
        HostRdData  = rdDataReg;
        case (rdState)
            RD_IDLE: begin
                if (HostRdReq) rdStateNext = RD_ISSUE;
            end
            RD_ISSUE: begin
                qStatREn    = 1'b1;
                HostRdAck   = 1'b1;
                rdStateNext = RD_WAIT1;
            end
            RD_WAIT1: begin
                rdStateNext = RD_WAIT2;
            end
            RD_WAIT2: begin
                // RAM data is live this cycle; present it now and hold it afterwards
                HostRdVal   = 1'b1;
                HostRdData  = qvStatRData;
                rdStateNext = RD_IDLE;
            end
            default: rdStateNext = RD_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            rdAddrReg <= '0;
            rdDataReg <= '0;
        end else begin
            if (rdState == RD_IDLE && HostRdReq) rdAddrReg <= HostRdAddr;
            if (rdState == RD_WAIT2) rdDataReg <= qvStatRData;
        end
    end

    assign qvStatRAddr = rdAddrReg;

endmodule

// File: tb/tb_stat_updt_sched.sv
// Directed self-checking bench for stat_updt_sched (default parameters).
module tb_stat_updt_sched;
    localparam int REQ_CNT = 4;
    localparam int IW      = 1;
    localparam int DEPTH   = 4;
`ifdef STAT_SCHED_OVF_FLAG_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic                   Clock = 1'b0;
    logic                   nReset = 1'b0;
    logic [REQ_CNT-1:0]     vUpdtReq = '0;
    logic [REQ_CNT*10-1:0]  vUpdtIndex = '0;
    logic [REQ_CNT*IW-1:0]  vUpdtNum = '0;
    logic [REQ_CNT-1:0]     vUpdtFull;
    logic [REQ_CNT-1:0]     vUpdtOvf;
    logic                   HostRdReq = 1'b0;
    logic [9:0]             HostRdAddr = '0;
    logic                   HostRdAck;
    logic                   HostRdVal;
    logic [63:0]            HostRdData;
    logic                   qStatUpdtReq;
    logic [9:0]             qvStatUpdtReqIndex;
    logic [IW-1:0]          qvStatUpdtNum;
    logic                   qStatREn;
    logic [9:0]             qvStatRAddr;
    logic [63:0]            qvStatRData;

    stat_updt_sched #(.REQ_CNT(REQ_CNT), .INC_LEN_BIT_WIDTH(IW), .FIFO_DEPTH(DEPTH)) dut (
        .Clock(Clock), .nReset(nReset),
        .vUpdtReq(vUpdtReq), .vUpdtIndex(vUpdtIndex), .vUpdtNum(vUpdtNum),
        .vUpdtFull(vUpdtFull), .vUpdtOvf(vUpdtOvf),
        .HostRdReq(HostRdReq), .HostRdAddr(HostRdAddr), .HostRdAck(HostRdAck),
        .HostRdVal(HostRdVal), .HostRdData(HostRdData),
        .qStatUpdtReq(qStatUpdtReq), .qvStatUpdtReqIndex(qvStatUpdtReqIndex),
        .qvStatUpdtNum(qvStatUpdtNum), .qStatREn(qStatREn), .qvStatRAddr(qvStatRAddr),
        .qvStatRData(qvStatRData)
    );

    always #5 Clock = ~Clock;

    // RAM model: data valid exactly two cycles after qStatREn, garbage otherwise
    logic [1:0]  renPipe = '0;
    logic [63:0] ramVal = '0;
    always @(posedge Clock) renPipe <= {renPipe[0], qStatREn};
    assign qvStatRData = renPipe[1] ? ramVal : 64'hBAD0_BAD0_BAD0_BAD0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct { int cyc; logic [9:0] idx; logic num; } updEv_t;
    updEv_t      updQ[$];
    int          consecUpd = 0, consecRen = 0, bothCnt = 0, renCnt = 0, valCnt = 0;
    int          minRenGap = 1000, lastRenCyc = -1;
    logic        prevUpd = 1'b0, prevRen = 1'b0;
    logic [63:0] lastRdData = '0;

    always @(negedge Clock) begin
        if (qStatUpdtReq) begin
            updQ.push_back('{cyc, qvStatUpdtReqIndex, qvStatUpdtNum[0]});
            $display("upd  cyc=%0d idx=%0d num=%0d", cyc, qvStatUpdtReqIndex, qvStatUpdtNum);
            if (prevUpd) consecUpd <= consecUpd + 1;
        end
        if (qStatREn) begin
            $display("ren  cyc=%0d addr=%h", cyc, qvStatRAddr);
            renCnt <= renCnt + 1;
            if (prevRen) consecRen <= consecRen + 1;
            if (lastRenCyc >= 0 && cyc - lastRenCyc < minRenGap) minRenGap <= cyc - lastRenCyc;
            lastRenCyc <= cyc;
        end
        if (qStatUpdtReq && qStatREn) bothCnt <= bothCnt + 1;
        if (HostRdVal) begin
            $display("rval cyc=%0d data=%h", cyc, HostRdData);
            valCnt <= valCnt + 1;
            lastRdData <= HostRdData;
        end
        prevUpd <= qStatUpdtReq;
        prevRen <= qStatREn;
    end

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic checkUpd(input string tag, input int k, input int expCyc,
                            input int expIdx, input int expNum);
        if (updQ.size() > k) begin
            checkVal({tag, "_cyc"}, 64'(updQ[k].cyc), 64'(expCyc));
            checkVal({tag, "_idx"}, 64'(updQ[k].idx), 64'(expIdx));
            checkVal({tag, "_num"}, 64'(updQ[k].num), 64'(expNum));
        end else begin
            checkVal({tag, "_present"}, 64'(updQ.size()), 64'(k + 1));
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic clrIn();
        vUpdtReq = '0; vUpdtIndex = '0; vUpdtNum = '0; HostRdReq = 1'b0; HostRdAddr = '0;
    endtask

    task automatic doReset();
        clrIn();
        nReset = 1'b0;
        step(2);
        nReset = 1'b1;
    endtask

    task automatic clearMon();
        updQ.delete();
        consecUpd = 0; consecRen = 0; bothCnt = 0; renCnt = 0; valCnt = 0;
        minRenGap = 1000; lastRenCyc = -1;
    endtask

    task automatic setReq(input int i, input logic [9:0] idx, input logic num);
        vUpdtReq[i] = 1'b1;
        vUpdtIndex[10*i +: 10] = idx;
        vUpdtNum[i] = num;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        int c0;
        int expIdx3 [9];
        logic fullAt [10];
        logic [3:0] expOvf;

        // Reset state
        doReset();
        checkVal("rst_upd",   64'(qStatUpdtReq), 64'd0);
        checkVal("rst_ren",   64'(qStatREn), 64'd0);
        checkVal("rst_ack",   64'(HostRdAck), 64'd0);
        checkVal("rst_val",   64'(HostRdVal), 64'd0);
        checkVal("rst_data",  HostRdData, 64'd0);
        checkVal("rst_full",  64'(vUpdtFull), 64'd0);
        checkVal("rst_ovf",   64'(vUpdtOvf), 64'd0);

        // 1: single update, one cycle latency
        clearMon(); c0 = cyc;
        setReq(0, 10'd5, 1'b1);
        step(1); clrIn();
        step(6);
        checkVal("t1_count", 64'(updQ.size()), 64'd1);
        checkUpd("t1", 0, c0 + 1, 5, 1);

        // 2: four simultaneous requesters from pointer 0
        doReset(); clearMon(); c0 = cyc;
        for (int i = 0; i < 4; i++) setReq(i, 10'(10 + i), ~i[0]);
        step(1); clrIn();
        step(10);
        checkVal("t2_count", 64'(updQ.size()), 64'd4);
        for (int k = 0; k < 4; k++) checkUpd($sformatf("t2_%0d", k), k, c0 + 1 + 2*k, 10 + k, (k % 2 == 0) ? 1 : 0);

        // 2b: pointer back at 0 -> req0 beats req3
        clearMon(); c0 = cyc;
        setReq(3, 10'd43, 1'b0); setReq(0, 10'd40, 1'b1);
        step(1); clrIn(); step(6);
        checkUpd("t2b_0", 0, c0 + 1, 40, 1);
        checkUpd("t2b_1", 1, c0 + 3, 43, 0);

        // 2c: after a req1 grant the pointer is 2, so req3 wins over req1 (wraparound)
        setReq(1, 10'd21, 1'b0); step(1); clrIn(); step(4);
        clearMon(); c0 = cyc;
        setReq(1, 10'd61, 1'b1); setReq(3, 10'd63, 1'b1);
        step(1); clrIn(); step(6);
        checkUpd("t2c_0", 0, c0 + 1, 63, 1);
        checkUpd("t2c_1", 1, c0 + 3, 61, 1);

        // 3: one push per cycle against one pop per two cycles fills after 8 pushes;
        //    the push in the full cycle is dropped although a pop happens in that cycle
        doReset(); clearMon(); c0 = cyc;
        for (int k = 0; k < 10; k++) begin
            setReq(2, 10'(100 + k), k[0]);
            fullAt[k] = vUpdtFull[2];
            step(1);
        end
        clrIn();
        step(20);
        checkVal("t3_full7", 64'(fullAt[7]), 64'd0);
        checkVal("t3_full8", 64'(fullAt[8]), 64'd1);
        checkVal("t3_full9", 64'(fullAt[9]), 64'd0);
        checkVal("t3_count", 64'(updQ.size()), 64'd9);
        for (int j = 0; j < 8; j++) expIdx3[j] = 100 + j;
        expIdx3[8] = 109;
        for (int j = 0; j < 9; j++)
            checkUpd($sformatf("t3_%0d", j), j, c0 + 1 + 2*j, expIdx3[j], expIdx3[j] % 2);
        expOvf = '0; expOvf[2] = OVF_EXP;
        checkVal("t3_ovf", 64'(vUpdtOvf), 64'(expOvf));
        checkVal("t3_drained", 64'(vUpdtFull), 64'd0);

        // 4: host read
        doReset(); clearMon(); ramVal = 64'h1234;
        HostRdReq = 1'b1; HostRdAddr = 10'h3FF;
        step(1);
        checkVal("t4_ack",  64'(HostRdAck), 64'd1);
        checkVal("t4_ren",  64'(qStatREn), 64'd1);
        checkVal("t4_addr", 64'(qvStatRAddr), 64'h3FF);
        HostRdReq = 1'b0;
        step(1);
        checkVal("t4_val2", 64'(HostRdVal), 64'd0);
        checkVal("t4_ren2", 64'(qStatREn), 64'd0);
        step(1);
        checkVal("t4_val3",  64'(HostRdVal), 64'd1);
        checkVal("t4_data3", HostRdData, 64'h1234);
        step(1);
        checkVal("t4_val4",  64'(HostRdVal), 64'd0);
        checkVal("t4_hold4", HostRdData, 64'h1234);

        // 5: reads held back-to-back concurrent with 3 queued updates
        doReset(); clearMon(); ramVal = 64'hFEED_0000_0000_0055;
        for (int i = 0; i < 3; i++) setReq(i, 10'(200 + i), 1'b1);
        HostRdReq = 1'b1; HostRdAddr = 10'h055;
        step(1);
        vUpdtReq = '0;
        step(13);
        HostRdReq = 1'b0;
        step(6);
        checkVal("t5_upds",   64'(updQ.size()), 64'd3);
        checkVal("t5_both",   64'(bothCnt), 64'd2);
        checkVal("t5_cupd",   64'(consecUpd), 64'd0);
        checkVal("t5_cren",   64'(consecRen), 64'd0);
        checkVal("t5_gap",    64'(minRenGap), 64'd4);
        checkVal("t5_rens",   64'(renCnt), 64'd4);
        checkVal("t5_vals",   64'(valCnt), 64'd4);
        checkVal("t5_rdata",  lastRdData, 64'hFEED_0000_0000_0055);

        // 6: reset with 2 updates queued and a read in WAIT1
        doReset(); clearMon(); ramVal = 64'h77;
        for (int i = 0; i < 3; i++) setReq(i, 10'(300 + i), 1'b0);
        HostRdReq = 1'b1; HostRdAddr = 10'h007;
        step(1);
        checkVal("t6_setup_upd", 64'(qStatUpdtReq), 64'd1);
        checkVal("t6_setup_ren", 64'(qStatREn), 64'd1);
        clrIn();
        step(1);
        nReset = 1'b0;
        step(1);
        nReset = 1'b1;
        clearMon();
        step(12);
        checkVal("t6_upds", 64'(updQ.size()), 64'd0);
        checkVal("t6_rens", 64'(renCnt), 64'd0);
        checkVal("t6_vals", 64'(valCnt), 64'd0);
        checkVal("t6_full", 64'(vUpdtFull), 64'd0);
        checkVal("t6_data", HostRdData, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
